// File: rtl/tpm_fifo_pkg.sv
// Shared definitions for the TPM FIFO-interface block: register offsets,
// STS/ACCESS bit positions and the command FSM encoding.
package tpm_fifo_pkg;

    // Register offsets within a locality's 4 KiB window
    localparam logic [11:0] RegAccess = 12'h000;
    localparam logic [11:0] RegSts    = 12'h018;
    localparam logic [11:0] RegFifo   = 12'h024;
    localparam logic [11:0] RegDidVid = 12'hF00;

    localparam int unsigned NumLoc = 5;

    // TPM_STS byte 0 bit positions
    localparam int unsigned StsValid     = 7;
    localparam int unsigned StsCmdReady  = 6;
    localparam int unsigned StsGo        = 5;
    localparam int unsigned StsDataAvail = 4;
    localparam int unsigned StsExpect    = 3;

    // TPM_ACCESS bit positions
    localparam int unsigned AccValid   = 7;
    localparam int unsigned AccActive  = 5;
    localparam int unsigned AccPending = 2;
    localparam int unsigned AccReqUse  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StReception,
        StExecution,
        StCompletion
    } tpm_state_e;

endpackage

// File: rtl/tpm_fifo_if_locality_arb.sv
// TPM_ACCESS register: active locality, pending requests and grant logic.
module tpm_locality_arb
    import tpm_fifo_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       acc_wr_i,
    input  logic [2:0] wr_loc_i,
    input  logic       req_use_i,
    input  logic       relinquish_i,
    input  logic [2:0] rd_loc_i,
    output logic       active_valid_o,
    output logic [2:0] active_loc_o,
    output logic       release_o,
    output logic [7:0] rdata_o
);

    logic              active_valid_q, active_valid_d;
    logic [2:0]        active_loc_q, active_loc_d;
    logic [NumLoc-1:0] pending_q, pending_d;
    logic              own_active;
    logic [2:0]        low_idx;

    assign own_active = active_valid_q && (active_loc_q == wr_loc_i);

    // Lowest-numbered pending locality wins the next grant
    always_comb begin
        low_idx = '0;
        for (int i = NumLoc - 1; i >= 0; i--) begin
            if (pending_q[i]) low_idx = 3'(i);
        end
    end

    // Request/release handling; a release in the same write is applied first
    always_comb begin
        active_valid_d = active_valid_q;
        active_loc_d   = active_loc_q;
        pending_d      = pending_q;
        release_o      = 1'b0;
        if (acc_wr_i) begin
            if (relinquish_i && own_active) begin
                release_o      = 1'b1;
                active_valid_d = 1'b0;
            end
            if (req_use_i) begin
                if (!active_valid_q && (pending_q == '0)) begin
                    active_valid_d = 1'b1;
                    active_loc_d   = wr_loc_i;
                end else if (!own_active || release_o) begin
                    pending_d[wr_loc_i] = 1'b1;
                end
            end
        end
        // Grant waits one cycle after a release so the release settles first
        if (!active_valid_q && (pending_q != '0)) begin
            active_valid_d     = 1'b1;
            active_loc_d       = low_idx;
            pending_d[low_idx] = 1'b0;
        end
    end

    // Arbitration state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_valid_q <= 1'b0;
            active_loc_q   <= '0;
            pending_q      <= '0;
        end else begin
            active_valid_q <= active_valid_d;
            active_loc_q   <= active_loc_d;
            pending_q      <= pending_d;
        end
    end

    // ACCESS read value as seen by the reading locality
    always_comb begin
        rdata_o             = '0;
        rdata_o[AccValid]   = 1'b1;
        rdata_o[AccActive]  = active_valid_q && (active_loc_q == rd_loc_i);
        rdata_o[AccPending] = |pending_q;
    end

    assign active_valid_o = active_valid_q;
    assign active_loc_o   = active_loc_q;

endmodule

// File: rtl/tpm_fifo_if.sv
// TPM FIFO-interface register block behind lpc_periph: decodes TPM cycles,
// moves command/response bytes through the buffer RAM and runs the
// exec/complete/abort handshake with firmware.
module tpm_fifo_if
    import tpm_fifo_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 11,
    parameter logic [31:0] DID_VID        = 32'h0123_1234
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [15:0]               lpc_addr_i,
    input  logic [7:0]                lpc_data_i,
    input  logic                      lpc_data_wr_i,
    output logic                      lpc_wr_done_o,
    input  logic                      lpc_data_req_i,
    output logic                      lpc_data_rd_o,
    output logic [7:0]                lpc_data_o,
    output logic                      exec_o,
    output logic                      abort_o,
    input  logic                      complete_i,
    output logic [3:0]                locality_o,
    output logic [RAM_ADDR_WIDTH-1:0] buf_len_o,
    input  logic [RAM_ADDR_WIDTH-1:0] resp_len_i,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [7:0]                ram_data_o,
    output logic                      ram_wr_o,
    input  logic [7:0]                ram_data_i
);

    localparam int unsigned Aw = RAM_ADDR_WIDTH;
    localparam logic [Aw:0] BufSize = {1'b1, {Aw{1'b0}}};

    tpm_state_e    state_q, state_d;
    logic [Aw:0]   wptr_q, wptr_d;
    logic [31:0]   cmd_size_q, cmd_size_d;
    logic [Aw-1:0] rptr_q, rptr_d, rlen_q, rlen_d, buf_len_q, buf_len_d;
    logic [3:0]    loc_q, loc_d;
    logic          exec_q, exec_d, abort_q, abort_d;

    logic       wr_seen_q, wr_done_q, req_q, rd_slot_q, rd_q;
    logic [7:0] data_q;
    logic       cpl_s1_q, cpl_s2_q, cpl_s3_q;

    logic [3:0]  loc;
    logic [11:0] off;
    logic        loc_ok, loc_owner, hit_access, hit_sts, hit_fifo, hit_did;
    logic        wr_acc, rd_start, sts_wr, fifo_wr, fifo_rd, ram_wr, cpl_edge;
    logic        act_valid, arb_release, expect_flag, data_avail;
    logic [2:0]  act_loc;
    logic [7:0]  acc_rdata, sts_byte, rd_val;
    logic [15:0] burst;

    assign loc        = lpc_addr_i[15:12];
    assign off        = lpc_addr_i[11:0];
    assign loc_ok     = loc < 4'd5;
    // With no locality active, STS/FIFO are open to any valid locality
    assign loc_owner  = loc_ok && (!act_valid || (act_loc == loc[2:0]));
    assign hit_access = loc_ok && (off == RegAccess);
    assign hit_sts    = loc_ok && (off[11:2] == RegSts[11:2]);
    assign hit_fifo   = loc_ok && (off == RegFifo);
    assign hit_did    = loc_ok && (off[11:2] == RegDidVid[11:2]);

    assign wr_acc   = lpc_data_wr_i && !wr_seen_q;
    assign rd_start = lpc_data_req_i && !req_q;
    assign sts_wr   = wr_acc && hit_sts && loc_owner && (off[1:0] == 2'd0);
    assign fifo_wr  = wr_acc && hit_fifo && loc_owner && (state_q == StReception);
    assign fifo_rd  = rd_slot_q && hit_fifo && loc_owner && (state_q == StCompletion);
    assign ram_wr   = fifo_wr && (wptr_q != BufSize);
    assign cpl_edge = cpl_s2_q && !cpl_s3_q;

    tpm_locality_arb u_arb (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .acc_wr_i       (wr_acc && hit_access),
        .wr_loc_i       (loc[2:0]),
        .req_use_i      (lpc_data_i[AccReqUse]),
        .relinquish_i   (lpc_data_i[AccActive]),
        .rd_loc_i       (loc[2:0]),
        .active_valid_o (act_valid),
        .active_loc_o   (act_loc),
        .release_o      (arb_release),
        .rdata_o        (acc_rdata)
    );

    assign expect_flag = (state_q == StReception) &&
                         !((wptr_q >= (Aw+1)'(6)) && (32'(wptr_q) == cmd_size_q));
    assign data_avail  = (state_q == StCompletion) && (rptr_q < rlen_q);

    // STS status byte and burstCount
    always_comb begin
        sts_byte               = '0;
        sts_byte[StsValid]     = 1'b1;
        sts_byte[StsCmdReady]  = (state_q == StIdle);
        sts_byte[StsDataAvail] = data_avail;
        sts_byte[StsExpect]    = expect_flag;
        burst = '0;
        if (state_q == StReception) begin
            burst = 16'(BufSize - wptr_q);
        end else if (data_avail) begin
            burst = 16'(rlen_q - rptr_q);
        end
    end

    // Register read mux; anything not claimed below reads 0xFF
    always_comb begin
        rd_val = 8'hFF;
        if (hit_access) begin
            rd_val = acc_rdata;
        end else if (hit_did) begin
            rd_val = DID_VID[{off[1:0], 3'b000} +: 8];
        end else if (hit_sts && loc_owner) begin
            case (off[1:0])
                2'd0:    rd_val = sts_byte;
                2'd1:    rd_val = burst[7:0];
                2'd2:    rd_val = burst[15:8];
                default: rd_val = 8'h00;
            endcase
        end else if (hit_fifo && loc_owner && data_avail) begin
            rd_val = ram_data_i;
        end
    end

    // Command FSM next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        cmd_size_d = cmd_size_q;
        rptr_d     = rptr_q;
        rlen_d     = rlen_q;
        buf_len_d  = buf_len_q;
        loc_d      = loc_q;
        exec_d     = exec_q;
        abort_d    = abort_q;
        unique case (state_q)
            StIdle: begin
                if (sts_wr && lpc_data_i[StsCmdReady]) begin
                    state_d    = StReception;
                    wptr_d     = '0;
                    cmd_size_d = '0;
                end
            end
            StReception: begin
                if (ram_wr) begin
                    wptr_d = wptr_q + 1'b1;
                    // Header bytes 2..5 carry the big-endian commandSize
                    if ((wptr_q >= (Aw+1)'(2)) && (wptr_q <= (Aw+1)'(5))) begin
                        cmd_size_d = {cmd_size_q[23:0], lpc_data_i};
                    end
                end
                if (sts_wr) begin
                    if (lpc_data_i[StsCmdReady]) begin
                        state_d = StIdle;
                    end else if (lpc_data_i[StsGo] && !expect_flag) begin
                        state_d   = StExecution;
                        exec_d    = 1'b1;
                        buf_len_d = wptr_q[Aw-1:0];
                        loc_d     = loc;
                    end
                end
                if (arb_release) state_d = StIdle;
            end
            StExecution: begin
                if (sts_wr && lpc_data_i[StsCmdReady]) abort_d = 1'b1;
                if (cpl_edge) begin
                    exec_d  = 1'b0;
                    abort_d = 1'b0;
                    rlen_d  = resp_len_i;
                    rptr_d  = '0;
                    state_d = abort_q ? StIdle : StCompletion;
                end
            end
            StCompletion: begin
                if (fifo_rd && data_avail) rptr_d = rptr_q + 1'b1;
                if (sts_wr && lpc_data_i[StsCmdReady]) state_d = StIdle;
                if (arb_release) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            cmd_size_q <= '0;
            rptr_q     <= '0;
            rlen_q     <= '0;
            buf_len_q  <= '0;
            loc_q      <= '0;
            exec_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            cmd_size_q <= cmd_size_d;
            rptr_q     <= rptr_d;
            rlen_q     <= rlen_d;
            buf_len_q  <= buf_len_d;
            loc_q      <= loc_d;
            exec_q     <= exec_d;
            abort_q    <= abort_d;
        end
    end

    // LPC handshake: write ack next cycle, read data two cycles after request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_seen_q <= 1'b0;
            wr_done_q <= 1'b0;
            req_q     <= 1'b0;
            rd_slot_q <= 1'b0;
            rd_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_seen_q <= lpc_data_wr_i;
            wr_done_q <= wr_acc;
            req_q     <= lpc_data_req_i;
            rd_slot_q <= rd_start;
            rd_q      <= rd_slot_q;
            if (rd_slot_q) data_q <= rd_val;
        end
    end

    // complete_i crosses from the WB domain: 2-flop sync plus edge history
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpl_s1_q <= 1'b0;
            cpl_s2_q <= 1'b0;
            cpl_s3_q <= 1'b0;
        end else begin
            cpl_s1_q <= complete_i;
            cpl_s2_q <= cpl_s1_q;
            cpl_s3_q <= cpl_s2_q;
        end
    end

    assign lpc_wr_done_o = wr_done_q;
    assign lpc_data_rd_o = rd_q;
    assign lpc_data_o    = data_q;
    assign exec_o        = exec_q;
    assign abort_o       = abort_q;
    assign locality_o    = loc_q;
    assign buf_len_o     = buf_len_q;
    assign ram_wr_o      = ram_wr;
    assign ram_data_o    = ram_wr ? lpc_data_i : 8'h00;
    assign ram_addr_o    = fifo_wr ? wptr_q[Aw-1:0] : rptr_q;

endmodule

// File: tb/tb_tpm_fifo_if.sv
// Scoreboard bench for tpm_fifo_if: expected read data and RAM writes are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_tpm_fifo_if;

    localparam int unsigned Aw = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   lpc_addr;
    logic [7:0]    lpc_wdata;
    logic          lpc_wr, lpc_req, complete;
    logic          wr_done, rd_valid, exec_s, abort_s, ram_wr;
    logic [7:0]    rdata, ram_wdata, ram_rdata;
    logic [3:0]    locality;
    logic [Aw-1:0] buf_len, resp_len, ram_addr;

    logic [7:0]  mem [0:(1<<Aw)-1];
    logic [7:0]  rd_q [$];
    logic [18:0] wq [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          next_waddr;
    logic [7:0]  cmd [12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C,
                              8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};

    always #5 clk = ~clk;

    tpm_fifo_if #(.RAM_ADDR_WIDTH(Aw), .DID_VID(32'h0123_1234)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .lpc_addr_i     (lpc_addr),
        .lpc_data_i     (lpc_wdata),
        .lpc_data_wr_i  (lpc_wr),
        .lpc_wr_done_o  (wr_done),
        .lpc_data_req_i (lpc_req),
        .lpc_data_rd_o  (rd_valid),
        .lpc_data_o     (rdata),
        .exec_o         (exec_s),
        .abort_o        (abort_s),
        .complete_i     (complete),
        .locality_o     (locality),
        .buf_len_o      (buf_len),
        .resp_len_i     (resp_len),
        .ram_addr_o     (ram_addr),
        .ram_data_o     (ram_wdata),
        .ram_wr_o       (ram_wr),
        .ram_data_i     (ram_rdata)
    );

    // Buffer RAM model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (ram_wr) check_val("ram_wr_in_reset", {31'd0, ram_wr}, 32'd0);
        end else if (ram_wr) begin
            if (wq.size() == 0) begin
                check_val("ram_wr_unexpected", {21'd0, ram_addr}, 32'hFFFF);
            end else begin
                logic [18:0] e;
                e = wq.pop_front();
                check_val("ram_wr_addr", {21'd0, ram_addr}, {21'd0, e[18:8]});
                check_val("ram_wr_data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic lpc_write(input logic [15:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        lpc_addr = a; lpc_wdata = d; lpc_wr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wr_done) begin got = 1'b1; break; end
        end
        lpc_wr = 1'b0;
        check_val($sformatf("wr_done_%04h", a), {31'd0, got}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic read_exp(input logic [15:0] a, input logic [7:0] e, input string tag);
        logic got;
        logic [7:0] exp_v;
        got = 1'b0;
        rd_q.push_back(e);
        lpc_addr = a; lpc_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rd_valid) begin got = 1'b1; break; end
        end
        exp_v = rd_q.pop_front();
        if (got) check_val(tag, {24'd0, rdata}, {24'd0, exp_v});
        else check_val({tag, "_rd_timeout"}, {31'd0, got}, 32'd1);
        lpc_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fifo_byte(input logic [15:0] a, input logic [7:0] d);
        wq.push_back({11'(next_waddr), d});
        next_waddr++;
        lpc_write(a, d);
    endtask

    // Drive complete_i (held 4 cycles) and count cycles until exec_o drops
    task automatic pulse_complete(input logic [Aw-1:0] rl);
        int n;
        n = 0;
        resp_len = rl; complete = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n++;
            if (!exec_s) break;
        end
        check_val("exec_fall_within_3", {31'd0, n <= 3}, 32'd1);
        @(posedge clk); #1;
        complete = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_ctl"}, {26'd0, wr_done, rd_valid, exec_s, abort_s, ram_wr, 1'b0}, 32'd0);
        check_val({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        check_val({tag, "_loc"}, {28'd0, locality}, 32'd0);
        check_val({tag, "_buflen"}, {21'd0, buf_len}, 32'd0);
        check_val({tag, "_ram"}, {13'd0, ram_addr, ram_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; lpc_addr = '0; lpc_wdata = '0; lpc_wr = 1'b0; lpc_req = 1'b0;
        complete = 1'b0; resp_len = '0; next_waddr = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        read_exp(16'h0000, 8'h80, "access_reset");
        read_exp(16'h0018, 8'hC0, "sts_reset");
        read_exp(16'h0F00, 8'h34, "did_vid_b0");
        read_exp(16'h0F03, 8'h01, "did_vid_b3");
        lpc_write(16'h1100, 8'h55);
        read_exp(16'h1100, 8'hFF, "unmapped");
        read_exp(16'h5000, 8'hFF, "locality5");

        // Locality arbitration
        lpc_write(16'h0000, 8'h02);
        read_exp(16'h0000, 8'hA0, "access_loc0_active");
        lpc_write(16'h1000, 8'h02);
        read_exp(16'h1000, 8'h84, "access_loc1_pending");
        lpc_write(16'h0000, 8'h20);
        read_exp(16'h1000, 8'hA0, "access_loc1_granted");
        read_exp(16'h0018, 8'hFF, "sts_non_active");

        // Command reception
        lpc_write(16'h1018, 8'h40);
        read_exp(16'h1018, 8'h88, "sts_reception");
        read_exp(16'h101A, 8'h08, "burst_empty_hi");
        for (int i = 0; i < 12; i++) begin
            fifo_byte(16'h1024, cmd[i]);
            read_exp(16'h1018, (i < 11) ? 8'h88 : 8'h80, $sformatf("expect_after_%0d", i + 1));
        end
        read_exp(16'h1019, 8'hF4, "burst_free_lo");
        lpc_write(16'h1018, 8'h20);
        check_val("exec_after_go", {31'd0, exec_s}, 32'd1);
        check_val("buf_len", {21'd0, buf_len}, 32'd12);
        check_val("locality_o", {28'd0, locality}, 32'd1);
        read_exp(16'h1018, 8'h80, "sts_execution");
        read_exp(16'h1024, 8'hFF, "fifo_rd_execution");

        // Response
        pulse_complete(11'd10);
        check_val("exec_after_complete", {31'd0, exec_s}, 32'd0);
        read_exp(16'h1018, 8'h90, "sts_completion");
        read_exp(16'h1019, 8'h0A, "burst_resp");
        for (int i = 0; i < 10; i++) begin
            read_exp(16'h1024, cmd[i], $sformatf("resp_byte_%0d", i));
        end
        read_exp(16'h1024, 8'hFF, "resp_past_end");
        read_exp(16'h1018, 8'h80, "sts_drained");

        // Abort path
        lpc_write(16'h1018, 8'h40);
        read_exp(16'h1018, 8'hC0, "sts_idle_again");
        lpc_write(16'h1018, 8'h40);
        next_waddr = 0;
        for (int i = 0; i < 6; i++) fifo_byte(16'h1024, (i == 5) ? 8'h06 : cmd[i]);
        read_exp(16'h1018, 8'h80, "expect_short_cmd");
        lpc_write(16'h1018, 8'h20);
        check_val("buf_len_short", {21'd0, buf_len}, 32'd6);
        lpc_write(16'h1018, 8'h40);
        check_val("abort_set", {30'd0, abort_s, exec_s}, 32'd3);
        read_exp(16'h1018, 8'h80, "sts_still_exec");
        pulse_complete(11'd4);
        check_val("abort_cleared", {31'd0, abort_s}, 32'd0);
        read_exp(16'h1018, 8'hC0, "sts_idle_after_abort");

        // Reset in the middle of reception
        lpc_write(16'h1018, 8'h40);
        next_waddr = 0;
        for (int i = 0; i < 5; i++) fifo_byte(16'h1024, cmd[i]);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        read_exp(16'h1000, 8'h80, "access_after_reset");
        lpc_write(16'h0000, 8'h02);
        lpc_write(16'h0018, 8'h40);
        next_waddr = 0;
        fifo_byte(16'h0024, 8'hAB);
        read_exp(16'h0018, 8'h88, "sts_new_cmd");
        check_val("ram_wr_queue_empty", wq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
